// File: rtl/load_store_unit.sv
// RV32I load/store unit: one word-wide memory transaction per request, with byte-lane
// steering for stores, load extraction/extension, and misalign/illegal/timeout errors.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [6:0]  req_opcode_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;

    typedef enum logic [1:0] {StIdle, StBus, StDone} state_e;

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        is_load, is_store, legal, misaligned;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    always_comb begin
        is_load  = (req_opcode_i == OpLoad);
        is_store = (req_opcode_i == OpStore);
        legal    = 1'b0;
        if (is_load) begin
            legal = (req_funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        end else if (is_store) begin
            legal = (req_funct3_i inside {3'b000, 3'b001, 3'b010});
        end
        unique case (req_funct3_i[1:0])
            2'b01:   misaligned = req_addr_i[0];
            2'b10:   misaligned = (req_addr_i[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end

    // Lane extraction uses the latched offset; mem_rdata is only meaningful in the ack cycle.
    always_comb begin
        unique case (addr_q[1:0])
            2'b00:   ld_byte = mem_rdata_i[7:0];
            2'b01:   ld_byte = mem_rdata_i[15:8];
            2'b10:   ld_byte = mem_rdata_i[23:16];
            default: ld_byte = mem_rdata_i[31:24];
        endcase
        ld_half = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (f3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'h0, ld_byte};
            3'b101:  ld_ext = {16'h0, ld_half};
            default: ld_ext = mem_rdata_i;
        endcase
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    we_d    = is_store;
                    f3_d    = req_funct3_i;
                    addr_d  = req_addr_i;
                    cnt_d   = 32'd0;
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                    be_d    = 4'b1111;
                    wdata_d = 32'd0;
                    if (is_store) begin
                        unique case (req_funct3_i[1:0])
                            2'b00: begin
                                be_d    = 4'b0001 << req_addr_i[1:0];
                                wdata_d = {4{req_wdata_i[7:0]}};
                            end
                            2'b01: begin
                                be_d    = req_addr_i[1] ? 4'b1100 : 4'b0011;
                                wdata_d = {2{req_wdata_i[15:0]}};
                            end
                            default: wdata_d = req_wdata_i;
                        endcase
                    end
                    if (!legal || misaligned) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        state_d = StBus;
                    end
                end
            end
            StBus: begin
                if (mem_ack_i) begin
                    rdata_d = we_q ? 32'd0 : ld_ext;
                    err_d   = 1'b0;
                    state_d = StDone;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q + 32'd1 >= TIMEOUT_CYCLES)) begin
                    rdata_d = 32'd0;
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= 32'd0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            cnt_q   <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Bus and response outputs are gated by state so they read as zero when inactive.
    always_comb begin
        req_ready_o  = (state_q == StIdle);
        mem_req_o    = (state_q == StBus);
        mem_we_o     = mem_req_o & we_q;
        mem_addr_o   = mem_req_o ? {addr_q[31:2], 2'b00} : 32'd0;
        mem_be_o     = mem_req_o ? be_q : 4'd0;
        mem_wdata_o  = mem_req_o ? wdata_q : 32'd0;
        resp_valid_o = (state_q == StDone);
        resp_rdata_o = resp_valid_o ? rdata_q : 32'd0;
        resp_err_o   = resp_valid_o & err_q;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (timeout configured to 8 cycles).
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [6:0]  req_opcode;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(8)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_opcode_i (req_opcode),
        .req_funct3_i (req_funct3),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .resp_valid_o (resp_valid),
        .resp_rdata_o (resp_rdata),
        .resp_err_o   (resp_err),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_be_o     (mem_be),
        .mem_wdata_o  (mem_wdata),
        .mem_ack_i    (mem_ack),
        .mem_rdata_i  (mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd);
        req_opcode = op;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        req_valid  = 1'b1;
        check("ready_at_accept", 32'(req_ready), 32'd1);
        tick();
        req_valid  = 1'b0;
        req_wdata  = 32'h0;
    endtask

    task automatic bus_txn(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd, input int ack_wait,
                           input logic [31:0] rd, input logic [3:0] exp_be,
                           input logic [31:0] exp_wd, input logic exp_we,
                           input logic [31:0] exp_rd);
        accept(op, f3, addr, wd);
        for (int i = 0; i <= ack_wait; i++) begin
            check({tag, " mem_req"}, 32'(mem_req), 32'd1);
            check({tag, " mem_addr"}, mem_addr, {addr[31:2], 2'b00});
            check({tag, " mem_be"}, 32'(mem_be), 32'(exp_be));
            check({tag, " mem_wdata"}, mem_wdata, exp_wd);
            check({tag, " mem_we"}, 32'(mem_we), 32'(exp_we));
            check({tag, " no_early_resp"}, 32'(resp_valid), 32'd0);
            if (i == ack_wait) begin
                mem_ack   = 1'b1;
                mem_rdata = rd;
            end
            tick();
        end
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        check({tag, " resp_valid"}, 32'(resp_valid), 32'd1);
        check({tag, " resp_rdata"}, resp_rdata, exp_rd);
        check({tag, " resp_err"}, 32'(resp_err), 32'd0);
        check({tag, " mem_req_drop"}, 32'(mem_req), 32'd0);
        check({tag, " ready_in_done"}, 32'(req_ready), 32'd0);
        tick();
        check({tag, " resp_pulse"}, 32'(resp_valid), 32'd0);
        check({tag, " back_idle"}, 32'(req_ready), 32'd1);
    endtask

    task automatic err_txn(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic [31:0] addr);
        accept(op, f3, addr, 32'hFFFF_FFFF);
        check({tag, " no_mem_req"}, 32'(mem_req), 32'd0);
        check({tag, " resp_valid"}, 32'(resp_valid), 32'd1);
        check({tag, " resp_err"}, 32'(resp_err), 32'd1);
        check({tag, " resp_rdata"}, resp_rdata, 32'd0);
        tick();
        check({tag, " resp_pulse"}, 32'(resp_valid), 32'd0);
        check({tag, " err_clear"}, 32'(resp_err), 32'd0);
        check({tag, " back_idle"}, 32'(req_ready), 32'd1);
        check({tag, " still_no_req"}, 32'(mem_req), 32'd0);
    endtask

    initial begin
        int hi_cycles;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_opcode = 7'h0;
        req_funct3 = 3'h0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        mem_ack    = 1'b0;
        mem_rdata  = 32'h0;
        tick();
        tick();
        check("rst ready", 32'(req_ready), 32'd1);
        check("rst mem_req", 32'(mem_req), 32'd0);
        check("rst resp_valid", 32'(resp_valid), 32'd0);
        check("rst resp_err", 32'(resp_err), 32'd0);
        check("rst mem_be", 32'(mem_be), 32'd0);
        check("rst mem_addr", mem_addr, 32'd0);
        rst_n = 1'b1;
        tick();

        bus_txn("sw", ST, 3'b010, 32'h104, 32'hDEADBEEF, 2, 32'h0, 4'b1111, 32'hDEADBEEF, 1'b1,
                32'h0);
        bus_txn("lb3", LD, 3'b000, 32'h203, 32'h0, 1, 32'h80FF7F01, 4'b1111, 32'h0, 1'b0,
                32'hFFFFFF80);
        bus_txn("lbu3", LD, 3'b100, 32'h203, 32'h0, 1, 32'h80FF7F01, 4'b1111, 32'h0, 1'b0,
                32'h00000080);
        bus_txn("lb0", LD, 3'b000, 32'h200, 32'h0, 1, 32'h80FF7F01, 4'b1111, 32'h0, 1'b0,
                32'h00000001);
        bus_txn("lh2", LD, 3'b001, 32'h202, 32'h0, 1, 32'h80011234, 4'b1111, 32'h0, 1'b0,
                32'hFFFF8001);
        bus_txn("lhu2", LD, 3'b101, 32'h202, 32'h0, 1, 32'h80011234, 4'b1111, 32'h0, 1'b0,
                32'h00008001);
        bus_txn("lh0", LD, 3'b001, 32'h200, 32'h0, 1, 32'h80011234, 4'b1111, 32'h0, 1'b0,
                32'h00001234);
        bus_txn("lw", LD, 3'b010, 32'h300, 32'h0, 1, 32'hCAFEF00D, 4'b1111, 32'h0, 1'b0,
                32'hCAFEF00D);
        bus_txn("sh2", ST, 3'b001, 32'h102, 32'h0000ABCD, 1, 32'h0, 4'b1100, 32'hABCDABCD, 1'b1,
                32'h0);
        bus_txn("sb1", ST, 3'b000, 32'h101, 32'h1234565A, 0, 32'h0, 4'b0010, 32'h5A5A5A5A, 1'b1,
                32'h0);

        err_txn("lw_mis", LD, 3'b010, 32'h101);
        err_txn("sh_mis", ST, 3'b001, 32'h103);
        err_txn("bad_op", 7'b0110011, 3'b000, 32'h100);
        err_txn("bad_f3", ST, 3'b100, 32'h100);

        // Timeout: no ack, bus request must hold for exactly 8 cycles.
        accept(LD, 3'b010, 32'h400, 32'h0);
        hi_cycles = 0;
        for (int i = 0; i < 40 && mem_req; i++) begin
            hi_cycles++;
            tick();
        end
        check("to cycles", 32'(hi_cycles), 32'd8);
        check("to resp_valid", 32'(resp_valid), 32'd1);
        check("to resp_err", 32'(resp_err), 32'd1);
        check("to resp_rdata", resp_rdata, 32'd0);
        tick();
        bus_txn("after_to", LD, 3'b100, 32'h401, 32'h0, 0, 32'h0000A500, 4'b1111, 32'h0, 1'b0,
                32'h000000A5);

        // Reset in the middle of a bus access.
        accept(LD, 3'b010, 32'h500, 32'h0);
        check("rst_mid req", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_mid drop", 32'(mem_req), 32'd0);
        check("rst_mid ready", 32'(req_ready), 32'd1);
        check("rst_mid no_resp", 32'(resp_valid), 32'd0);
        tick();
        check("rst_mid no_resp2", 32'(resp_valid), 32'd0);

        // Stray ack while idle.
        mem_ack   = 1'b1;
        mem_rdata = 32'h12345678;
        tick();
        mem_ack   = 1'b0;
        check("stray no_resp", 32'(resp_valid), 32'd0);
        check("stray no_req", 32'(mem_req), 32'd0);
        check("stray ready", 32'(req_ready), 32'd1);
        tick();
        check("stray no_resp2", 32'(resp_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
